// File: rtl/ifetch_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches whole lines over Wishbone classic and
// queues {pc, instr} pairs. Define IFETCH_STATS_EN to add saturating line/flush/stall counters.
module ifetch_prefetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                LINE_W   = 128,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   output logic                                 wb_cyc,
   output logic                                 wb_stb,
   output logic                                 wb_we,
   output logic [LINE_W/8-1:0]                  wb_sel,
   output logic [ADDR_W-$clog2(LINE_W/8)-1:0]   wb_adr,
   input  logic [LINE_W-1:0]                    wb_dat_i,
   input  logic                                 wb_ack,
   input  logic                                 wb_rty,
   input  logic                                 redirect_valid,
   input  logic [ADDR_W-1:0]                    redirect_pc,
   output logic                                 instr_valid,
   input  logic                                 instr_ready,
   output logic [15:0]                          instr,
   output logic [ADDR_W-1:0]                    instr_pc
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0]                          stat_lines,
   output logic [31:0]                          stat_flushes,
   output logic [31:0]                          stat_stall
`endif
);

   // state  | meaning
   // IDLE   | just out of reset, request issued next cycle
   // REQ    | bus cycle live (gap=0) or one-cycle pause before re-request (gap=1)
   // UNPACK | pushing words of the latched line into the queue
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_UNPACK} state_t;

   localparam int OFF   = $clog2(LINE_W/8);
   localparam int IDX_W = OFF - 1;
   localparam int ADW   = ADDR_W - OFF;
   localparam int W     = LINE_W / 16;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   state_t              state, state_n;
   logic                gap, gap_n;
   logic                kill, kill_n;
   logic [ADDR_W-1:0]   fetch_pc, fetch_pc_n;
   logic [ADW-1:0]      adr_q, adr_n;
   logic [LINE_W-1:0]   line_q;
   logic                line_load;
   logic                push, pop, full, live;
   logic [IDX_W-1:0]    idx;
   logic [15:0]         line_words [W];
   logic [15:0]         word;

   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [ADDR_W-1:0]   q_pc    [DEPTH];
   logic [15:0]         q_instr [DEPTH];

   for (genvar g = 0; g < W; g++) begin : g_words
      assign line_words[g] = line_q[g*16 +: 16];
   end

   assign idx  = fetch_pc[OFF-1:1];
   assign word = line_words[idx];
   assign full = (count == CNT_W'(DEPTH));
   assign live = (state == S_REQ) && !gap;

   assign wb_cyc = live;
   assign wb_stb = live;
   assign wb_we  = 1'b0;
   assign wb_sel = '1;
   assign wb_adr = adr_q;

   always_comb begin
      state_n    = state;
      gap_n      = gap;
      kill_n     = kill;
      fetch_pc_n = fetch_pc;
      line_load  = 1'b0;
      push       = 1'b0;
      case (state)
         S_IDLE: state_n = S_REQ;
         S_REQ: begin
            if (gap) begin
               gap_n = 1'b0;
            end else if (wb_ack) begin
               kill_n = 1'b0;
               if (!kill && !redirect_valid) begin
                  line_load = 1'b1;
                  state_n   = S_UNPACK;
               end else begin
                  gap_n = 1'b1;
               end
            end else if (wb_rty) begin
               // the retried cycle carries no data, so nothing stale is left to discard
               gap_n  = 1'b1;
               kill_n = 1'b0;
            end else if (redirect_valid) begin
               kill_n = 1'b1;
            end
         end
         S_UNPACK: begin
            if (redirect_valid) begin
               state_n = S_REQ;
            end else if (!full) begin
               push       = 1'b1;
               fetch_pc_n = fetch_pc + ADDR_W'(2);
               if (&idx) state_n = S_REQ;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (redirect_valid) fetch_pc_n = redirect_pc & ~ADDR_W'(1);
      // address stays frozen for the whole live cycle even if fetch_pc is redirected
      adr_n = (live && !wb_ack && !wb_rty) ? adr_q : fetch_pc_n[ADDR_W-1:OFF];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         gap      <= 1'b0;
         kill     <= 1'b0;
         fetch_pc <= RESET_PC & ~ADDR_W'(1);
         adr_q    <= '0;
         line_q   <= '0;
      end else begin
         state    <= state_n;
         gap      <= gap_n;
         kill     <= kill_n;
         fetch_pc <= fetch_pc_n;
         adr_q    <= adr_n;
         if (line_load) line_q <= wb_dat_i;
      end
   end

   assign instr_valid = (count != '0);
   assign pop         = instr_valid && instr_ready && !redirect_valid;
   assign instr       = instr_valid ? q_instr[rd_ptr] : 16'h0000;
   assign instr_pc    = instr_valid ? q_pc[rd_ptr]    : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]    <= fetch_pc;
         q_instr[wr_ptr] <= word;
      end
   end

`ifdef IFETCH_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_lines   <= '0;
         stat_flushes <= '0;
         stat_stall   <= '0;
      end else begin
         if (line_load && (stat_lines != '1))     stat_lines   <= stat_lines + 32'd1;
         if (redirect_valid && (stat_flushes != '1)) stat_flushes <= stat_flushes + 32'd1;
         if (instr_ready && !instr_valid && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
      end
   end
`else
   // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Bench for ifetch_prefetch_unit: Wishbone memory model plus an instruction-stream
// reference (expected pc/instr sequence restarted on every redirect).
module tb_ifetch_prefetch_unit;
   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;
   localparam int ADW    = 12;

   logic              clk, rst;
   logic              wb_cyc, wb_stb, wb_we;
   logic [15:0]       wb_sel;
   logic [ADW-1:0]    wb_adr;
   logic [LINE_W-1:0] wb_dat_i;
   logic              wb_ack, wb_rty;
   logic              redirect_valid;
   logic [15:0]       redirect_pc;
   logic              instr_valid, instr_ready;
   logic [15:0]       instr, instr_pc;
`ifdef IFETCH_STATS_EN
   logic [31:0]       stat_lines, stat_flushes, stat_stall;
`endif

   ifetch_prefetch_unit #(.ADDR_W(16), .LINE_W(128), .DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
      .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_rty(wb_rty),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef IFETCH_STATS_EN
      , .stat_lines(stat_lines), .stat_flushes(stat_flushes), .stat_stall(stat_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int          cyc_n = 0, ack_cyc = 0, pops = 0;
   logic [15:0] exp_pc;
   int          req_cnt;
   logic [11:0] req_log [64];
   logic [11:0] held_adr;
   bit          busy, rnd_lat, rnd_rty, rty_once, rty_done;
   int          lat, fix_lat;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // odd multiplier keeps every address mapping to a distinct word
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'h9E37;
      return t ^ 16'h5A5A;
   endfunction

   function automatic logic [127:0] line_for(input logic [11:0] adr);
      logic [127:0] l;
      logic [15:0]  base;
      base = {adr, 4'b0000};
      for (int i = 0; i < 8; i++) l[i*16 +: 16] = mem_word(base + 16'(2*i));
      return l;
   endfunction

   task automatic slave_update();
      wb_ack = 1'b0;
      wb_rty = 1'b0;
      check_eq("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
      if (busy) check_eq("cyc_hold", 32'(wb_cyc), 1);
      if (wb_cyc && wb_stb) begin
         if (!busy) begin
            busy     = 1'b1;
            held_adr = wb_adr;
            if (req_cnt < 64) req_log[req_cnt] = wb_adr;
            req_cnt++;
            lat = rnd_lat ? int'($urandom_range(0, 3)) : fix_lat;
         end else begin
            check_eq("adr_hold", 32'(wb_adr), 32'(held_adr));
         end
         if (lat == 0) begin
            busy = 1'b0;
            if (rty_once || (rnd_rty && $urandom_range(0, 7) == 0)) begin
               rty_once = 1'b0;
               rty_done = 1'b1;
               wb_rty   = 1'b1;
            end else begin
               wb_ack   = 1'b1;
               wb_dat_i = line_for(wb_adr);
               ack_cyc  = cyc_n;
            end
         end else begin
            lat--;
         end
      end else begin
         busy = 1'b0;
      end
   endtask

   task automatic monitor();
      if (redirect_valid) begin
         exp_pc = redirect_pc & 16'hFFFE;
      end else if (instr_valid && instr_ready) begin
         check_eq("stream_pc", 32'(instr_pc), 32'(exp_pc));
         check_eq("stream_instr", 32'(instr), 32'(mem_word(exp_pc)));
         exp_pc = exp_pc + 16'd2;
         pops++;
      end
   endtask

   task automatic step();
      slave_update();
      monitor();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
      wb_ack = 1'b0; wb_rty = 1'b0; wb_dat_i = '0;
      busy = 1'b0; req_cnt = 0; exp_pc = 16'h0000;
      rnd_lat = 1'b0; rnd_rty = 1'b0; rty_once = 1'b0; rty_done = 1'b0; fix_lat = 2;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int p0, rq, run;

      // reset state
      do_reset();
      check_eq("rst_cyc", 32'(wb_cyc), 0);
      check_eq("rst_stb", 32'(wb_stb), 0);
      check_eq("rst_we", 32'(wb_we), 0);
      check_eq("rst_sel", 32'(wb_sel), 32'hFFFF);
      check_eq("rst_adr", 32'(wb_adr), 0);
      check_eq("rst_valid", 32'(instr_valid), 0);
      check_eq("rst_instr", 32'(instr), 0);
      check_eq("rst_pc", 32'(instr_pc), 0);

      // 1: streaming one line, latency and next line request
      instr_ready = 1'b1;
      for (int n = 0; n < 20 && !instr_valid; n++) step();
      check_eq("t1_valid", 32'(instr_valid), 1);
      check_eq("t1_latency", 32'(cyc_n - ack_cyc), 2);
      check_eq("t1_adr0", 32'(req_log[0]), 0);
      run = 0;
      for (int k = 0; k < 8; k++) begin run += int'(instr_valid); step(); end
      check_eq("t1_run", 32'(run), 8);
      check_eq("t1_drained", 32'(instr_valid), 0);
      for (int n = 0; n < 10 && req_cnt < 2; n++) step();
      check_eq("t1_adr1", 32'(req_log[1]), 1);
      check_eq("t1_pops", 32'(pops), 8);

      // 2: full queue stalls unpacking, then drains without gaps
      do_reset();
      for (int k = 0; k < 20; k++) step();
      check_eq("t2_valid_held", 32'(instr_valid), 1);
      check_eq("t2_one_req", 32'(req_cnt), 1);
      check_eq("t2_no_cyc", 32'(wb_cyc), 0);
      p0 = pops;
      instr_ready = 1'b1;
      run = 0;
      for (int k = 0; k < 8; k++) begin run += int'(instr_valid); step(); end
      check_eq("t2_run", 32'(run), 8);
      check_eq("t2_pops", 32'(pops - p0), 8);
      check_eq("t2_empty", 32'(instr_valid), 0);

      // 3: redirect to a mid-line PC during unpack
      do_reset();
      instr_ready = 1'b1;
      for (int n = 0; n < 20 && !instr_valid; n++) step();
      redirect_valid = 1'b1; redirect_pc = 16'h0036;
      step();
      redirect_valid = 1'b0;
      check_eq("t3_flushed", 32'(instr_valid), 0);
      p0 = pops;
      for (int n = 0; n < 40 && req_cnt < 3; n++) step();
      check_eq("t3_adr3", 32'(req_log[1]), 3);
      check_eq("t3_adr4", 32'(req_log[2]), 4);
      check_eq("t3_pops", 32'(pops - p0), 5);

      // 4: redirect while the bus cycle waits; stale line discarded
      do_reset();
      fix_lat = 3;
      instr_ready = 1'b1;
      for (int n = 0; n < 10 && !wb_cyc; n++) step();
      step();
      redirect_valid = 1'b1; redirect_pc = 16'h0100;
      step();
      redirect_valid = 1'b0;
      check_eq("t4_cyc_kept", 32'(wb_cyc), 1);
      step();
      step();
      check_eq("t4_gap", 32'(wb_cyc), 0);
      step();
      check_eq("t4_recyc", 32'(wb_cyc), 1);
      check_eq("t4_adr", 32'(wb_adr), 32'h10);
      p0 = pops;
      for (int k = 0; k < 20; k++) step();
      check_eq("t4_pops", 32'(pops - p0 >= 6), 1);

      // 5: retry on first attempt
      do_reset();
      rty_once = 1'b1;
      instr_ready = 1'b1;
      for (int n = 0; n < 10 && !rty_done; n++) step();
      check_eq("t5_rty_seen", 32'(rty_done), 1);
      check_eq("t5_gap", 32'(wb_cyc), 0);
      step();
      check_eq("t5_recyc", 32'(wb_cyc), 1);
      check_eq("t5_same_adr", 32'(wb_adr), 0);
      p0 = pops;
      for (int k = 0; k < 15; k++) step();
      check_eq("t5_pops", 32'(pops - p0 >= 8), 1);

      // 6: redirect to the top of the address space wraps to line 0
      do_reset();
      fix_lat = 1;
      instr_ready = 1'b1;
      for (int n = 0; n < 20 && !instr_valid; n++) step();
      rq = req_cnt;
      redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
      step();
      redirect_valid = 1'b0;
      for (int n = 0; n < 60 && req_cnt < rq + 2; n++) step();
      check_eq("t6_adr_top", 32'(req_log[rq]), 32'hFFF);
      check_eq("t6_adr_wrap", 32'(req_log[rq+1]), 0);
`ifdef IFETCH_STATS_EN
      check_eq("t6_flushes", stat_flushes, 1);
`endif
      for (int k = 0; k < 10; k++) step();

      // randomized traffic against the stream reference
      do_reset();
      rnd_lat = 1'b1; rnd_rty = 1'b1;
      p0 = pops;
      for (int k = 0; k < 3000; k++) begin
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = 16'($urandom);
         step();
      end
      redirect_valid = 1'b0;
      check_eq("rnd_progress", 32'(pops - p0 >= 300), 1);

      // asynchronous reset drops a live cycle immediately
      do_reset();
      for (int n = 0; n < 10 && !wb_cyc; n++) step();
      check_eq("arst_pre", 32'(wb_cyc), 1);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_cyc", 32'(wb_cyc), 0);
      check_eq("arst_stb", 32'(wb_stb), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
